board_slide_merge: RTL and testbench

- Move-execution stage of the 2048 datapath; sits directly upstream of the random-tile placer.
- Takes the current 4x4 board and a player direction, then slides and merges tiles one lane per cycle using standard 2048 rules.
- Presents the new board together with moved, score and win indications.
- The controller starts the tile placer only when moved=1.

---
 rtl/game2048_pkg.sv | 25 ++
 rtl/lane_merge.sv | 58 +++++
 rtl/board_slide_merge.sv | 144 ++++++++++++++
 tb/tb_board_slide_merge.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game2048_pkg.sv
// Shared types and constants for the 2048 datapath.
package game2048_pkg;

  localparam int unsigned N = 4;
  localparam int unsigned TILE_W = 12;
  localparam logic [TILE_W-1:0] TILE_MAX = 12'h800;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_UP    = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  // [row][col], row 0 = top, col 0 = left
  typedef logic [N-1:0][N-1:0][TILE_W-1:0] board_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StProcess,
    StDone
  } slide_state_e;

endpackage

// File: rtl/lane_merge.sv
// Combinational 2048 slide/merge of one lane; tile 0 is nearest the move target.
module lane_merge #(
  parameter int unsigned TILE_W  = 12,
  parameter int unsigned SCORE_W = 16
) (
  input  logic [3:0][TILE_W-1:0] tiles_i,
  output logic [3:0][TILE_W-1:0] tiles_o,
  output logic [SCORE_W-1:0]     score_o,
  output logic                   win_o,
  output logic                   changed_o
);
  import game2048_pkg::*;

  localparam logic [TILE_W-1:0] TileMax = TILE_W'(TILE_MAX);

  // Extra always-zero slot so the last tile never finds a merge partner.
  logic [N:0][TILE_W-1:0] comp;
  logic [TILE_W-1:0]      dbl;
  logic [1:0]             ck;
  logic [1:0]             mk;
  logic                   skip;

  // Compress out zeros, then merge equal pairs once each, writing results densely.
  always_comb begin
    comp      = '0;
    ck        = '0;
    for (int i = 0; i < N; i++) begin
      if (tiles_i[i] != '0) begin
        comp[ck] = tiles_i[i];
        ck       = ck + 2'd1;
      end
    end

    tiles_o = '0;
    score_o = '0;
    win_o   = 1'b0;
    mk      = '0;
    skip    = 1'b0;
    dbl     = '0;
    for (int i = 0; i < N; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[i] != '0 && comp[i] == comp[i+1] && comp[i] != TileMax) begin
        dbl         = comp[i] << 1;
        tiles_o[mk] = dbl;
        score_o     = score_o + SCORE_W'(dbl);
        win_o       = win_o | (dbl == TileMax);
        mk          = mk + 2'd1;
        skip        = 1'b1;
      end else begin
        tiles_o[mk] = comp[i];
        mk          = mk + 2'd1;
      end
    end
    changed_o = (tiles_o != tiles_i);
  end

endmodule

// File: rtl/board_slide_merge.sv
// 2048 move execution: slides and merges the 4x4 board one lane per cycle.
module board_slide_merge #(
  parameter int unsigned TILE_W  = 12,
  parameter int unsigned SCORE_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [1:0]                  dir,
  input  logic [3:0][3:0][TILE_W-1:0] board_in,
  output logic [3:0][3:0][TILE_W-1:0] board_out,
  output logic                        moved,
  output logic [SCORE_W-1:0]          score_delta,
  output logic                        win,
  output logic                        busy,
  output logic                        done
);
  import game2048_pkg::*;

  slide_state_e state_q, state_d;
  dir_t dir_q, dir_d;
  logic [3:0][3:0][TILE_W-1:0] work_q, work_d;
  logic [3:0][3:0][TILE_W-1:0] board_q, board_d;
  logic moved_q, moved_d, win_q, win_d, busy_q, busy_d, done_q, done_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0]   score_sum;
  logic [1:0] lane_q, lane_d;

  logic [3:0][TILE_W-1:0] lane_tiles, lane_res;
  logic [SCORE_W-1:0]     lane_score;
  logic                   lane_win, lane_changed;

  // Gather the current lane from the captured board, t0 nearest the target edge.
  always_comb begin
    lane_tiles = '0;
    for (int k = 0; k < N; k++) begin
      unique case (dir_q)
        DIR_LEFT:  lane_tiles[k] = work_q[lane_q][2'(k)];
        DIR_RIGHT: lane_tiles[k] = work_q[lane_q][2'(3 - k)];
        DIR_UP:    lane_tiles[k] = work_q[2'(k)][lane_q];
        DIR_DOWN:  lane_tiles[k] = work_q[2'(3 - k)][lane_q];
      endcase
    end
  end

  lane_merge #(
    .TILE_W (TILE_W),
    .SCORE_W(SCORE_W)
  ) u_lane_merge (
    .tiles_i  (lane_tiles),
    .tiles_o  (lane_res),
    .score_o  (lane_score),
    .win_o    (lane_win),
    .changed_o(lane_changed)
  );

  assign score_sum = {1'b0, score_q} + {1'b0, lane_score};

  // Next-state logic: capture, copy, per-lane write-back and flag accumulation.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    work_d  = work_q;
    board_d = board_q;
    moved_d = moved_q;
    score_d = score_q;
    win_d   = win_q;
    lane_d  = lane_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          work_d  = board_in;
          dir_d   = dir_t'(dir);
          moved_d = 1'b0;
          score_d = '0;
          win_d   = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        board_d = work_q;
        lane_d  = '0;
        state_d = StProcess;
      end
      StProcess: begin
        for (int k = 0; k < N; k++) begin
          unique case (dir_q)
            DIR_LEFT:  board_d[lane_q][2'(k)]     = lane_res[k];
            DIR_RIGHT: board_d[lane_q][2'(3 - k)] = lane_res[k];
            DIR_UP:    board_d[2'(k)][lane_q]     = lane_res[k];
            DIR_DOWN:  board_d[2'(3 - k)][lane_q] = lane_res[k];
          endcase
        end
        moved_d = moved_q | lane_changed;
        score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        win_d   = win_q | lane_win;
        lane_d  = lane_q + 2'd1;
        if (lane_q == 2'd3) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dir_q   <= DIR_LEFT;
      work_q  <= '0;
      board_q <= '0;
      moved_q <= 1'b0;
      score_q <= '0;
      win_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      work_q  <= work_d;
      board_q <= board_d;
      moved_q <= moved_d;
      score_q <= score_d;
      win_q   <= win_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lane_q  <= lane_d;
    end
  end

  assign board_out   = board_q;
  assign moved       = moved_q;
  assign score_delta = score_q;
  assign win         = win_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_board_slide_merge.sv
// Bench for board_slide_merge: directed table, corner sequences, random vs model.
module tb_board_slide_merge;
  import game2048_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  dir;
  board_t      board_in;
  board_t      board_out;
  logic        moved;
  logic [15:0] score_delta;
  logic        win;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  board_slide_merge #(
    .TILE_W (12),
    .SCORE_W(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dir        (dir),
    .board_in   (board_in),
    .board_out  (board_out),
    .moved      (moved),
    .score_delta(score_delta),
    .win        (win),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  d;
    board_t      b;
    board_t      eb;
    logic        em;
    logic [15:0] es;
    logic        ew;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_board(input string name, input board_t act, input board_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic board_t mk_row0(input int a0, input int a1, input int a2, input int a3);
    board_t b = '0;
    b[0][0] = 12'(a0);
    b[0][1] = 12'(a1);
    b[0][2] = 12'(a2);
    b[0][3] = 12'(a3);
    return b;
  endfunction

  function automatic board_t mk_col0(input int a0, input int a1, input int a2, input int a3);
    board_t b = '0;
    b[0][0] = 12'(a0);
    b[1][0] = 12'(a1);
    b[2][0] = 12'(a2);
    b[3][0] = 12'(a3);
    return b;
  endfunction

  // Board coordinates of the k-th tile (0 = nearest target edge) of lane l.
  function automatic int row_of(input logic [1:0] d, input int l, input int k);
    case (d)
      2'b00, 2'b01: return l;
      2'b10:        return k;
      default:      return 3 - k;
    endcase
  endfunction

  function automatic int col_of(input logic [1:0] d, input int l, input int k);
    case (d)
      2'b00:   return k;
      2'b01:   return 3 - k;
      default: return l;
    endcase
  endfunction

  // Reference move: per lane, queue the non-empty tiles and pop them in order,
  // fusing a tile with the one behind it when they match.
  function automatic void ref_move(input board_t b, input logic [1:0] d, output board_t nb,
                                   output logic m, output logic [15:0] s, output logic w);
    int q[$];
    int res[$];
    int a;
    int v;
    int sc;
    nb = b;
    sc = 0;
    w  = 1'b0;
    for (int l = 0; l < 4; l++) begin
      q.delete();
      res.delete();
      for (int k = 0; k < 4; k++) begin
        v = int'(b[row_of(d, l, k)][col_of(d, l, k)]);
        if (v != 0) q.push_back(v);
      end
      while (q.size() > 0) begin
        a = q.pop_front();
        if (q.size() > 0 && q[0] == a && a != 2048) begin
          void'(q.pop_front());
          res.push_back(2 * a);
          sc += 2 * a;
          if (2 * a == 2048) w = 1'b1;
        end else begin
          res.push_back(a);
        end
      end
      while (res.size() < 4) res.push_back(0);
      for (int k = 0; k < 4; k++) nb[row_of(d, l, k)][col_of(d, l, k)] = 12'(res[k]);
    end
    m = (nb != b);
    s = (sc > 65535) ? 16'hffff : 16'(sc);
  endfunction

  // Issue one move; scrambles board_in/dir after capture. lat = edges from start to done.
  task automatic run_move(input logic [1:0] d, input board_t b, output int lat);
    bit seen;
    @(negedge clk);
    board_in = b;
    dir      = d;
    start    = 1'b1;
    lat      = 0;
    seen     = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start    = 1'b0;
      board_in = ~b;
      dir      = ~d;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles");
    end
  endtask

  task automatic apply(input string name, input logic [1:0] d, input board_t b,
                       input board_t eb, input logic em, input logic [15:0] es,
                       input logic ew);
    int lat;
    run_move(d, b, lat);
    check({name, "_latency"}, 64'(lat), 64'd6);
    check_board({name, "_board"}, board_out, eb);
    check({name, "_moved"}, 64'(moved), 64'(em));
    check({name, "_score"}, 64'(score_delta), 64'(es));
    check({name, "_win"}, 64'(win), 64'(ew));
    @(negedge clk);
    check({name, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
    check_board({name, "_hold"}, board_out, eb);
  endtask

  function automatic int rand_tile();
    int t;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: t = 0;
      4, 5:       t = 2;
      6:          t = 4;
      7:          t = 8;
      8:          t = 1024;
      default:    t = 2048;
    endcase
    return t;
  endfunction

  initial begin
    board_t rb;
    board_t eb;
    logic em;
    logic ew;
    logic [15:0] es;
    logic [1:0] rd;
    int pulses;

    vecs[0] = '{"l2222", 2'b00, mk_row0(2, 2, 2, 2), mk_row0(4, 4, 0, 0), 1'b1, 16'd8, 1'b0};
    vecs[1] = '{"r2220", 2'b01, mk_row0(2, 2, 2, 0), mk_row0(0, 0, 2, 4), 1'b1, 16'd4, 1'b0};
    vecs[2] = '{"l2220", 2'b00, mk_row0(2, 2, 2, 0), mk_row0(4, 2, 0, 0), 1'b1, 16'd4, 1'b0};
    vecs[3] = '{"u4048", 2'b10, mk_col0(4, 0, 4, 8), mk_col0(8, 8, 0, 0), 1'b1, 16'd8, 1'b0};
    vecs[4] = '{"noop", 2'b00, mk_col0(2, 4, 8, 16), mk_col0(2, 4, 8, 16), 1'b0, 16'd0,
                1'b0};
    vecs[5] = '{"win", 2'b00, mk_row0(1024, 1024, 2048, 2048), mk_row0(2048, 2048, 2048, 0),
                1'b1, 16'd2048, 1'b1};

    rst      = 1'b1;
    start    = 1'b0;
    dir      = 2'b00;
    board_in = mk_row0(2, 2, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_board("reset_board", board_out, '0);
    check("reset_flags", {58'd0, moved, win, busy, done, 2'b00}, 64'd0);
    check("reset_score", 64'(score_delta), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      apply(vecs[i].name, vecs[i].d, vecs[i].b, vecs[i].eb, vecs[i].em, vecs[i].es,
            vecs[i].ew);
    end

    // Reset lands on the edge that would write lane 2.
    @(negedge clk);
    board_in = mk_row0(2, 2, 2, 2);
    dir      = 2'b00;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_board("mid_reset_board", board_out, '0);
    check("mid_reset_flags", {60'd0, busy, done, moved, win}, 64'd0);
    check("mid_reset_score", 64'(score_delta), 64'd0);
    pulses = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (done) pulses++;
    end
    check("mid_reset_no_done", 64'(pulses), 64'd0);

    // Extra start pulses while busy must be dropped.
    @(negedge clk);
    board_in = mk_row0(2, 2, 2, 2);
    dir      = 2'b00;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    board_in = mk_row0(4, 4, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (done) pulses++;
    end
    check("busy_start_pulses", 64'(pulses), 64'd1);
    check_board("busy_start_board", board_out, mk_row0(4, 4, 0, 0));
    check("busy_start_score", 64'(score_delta), 64'd8);

    for (int n = 0; n < 150; n++) begin
      rb = '0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) rb[r][c] = 12'(rand_tile());
      end
      rd = 2'($urandom_range(0, 3));
      ref_move(rb, rd, eb, em, es, ew);
      apply($sformatf("rnd%0d", n), rd, rb, eb, em, es, ew);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
